shadmehr_muscle_array: RTL and testbench

- Time-multiplexed, parametrised Shadmehr muscle engine for NCH independent muscles, all in IEEE-754 single precision.
- One shared datapath (int_to_float, mult, add, sub) iterates over every channel on each simulation tick.
- Per-channel model: activation difference equation, length weighting s(x), force derivative d_force, and force integration.
- Sits between spike counters and the limb/plant model; replaces one shadmehr_muscle instance per muscle.

---
 rtl/shadmehr_muscle_array_if.sv | 25 ++
 rtl/shadmehr_muscle_array.sv | 237 +++++++++++++++++++++++
 tb/tb_shadmehr_muscle_array.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shadmehr_muscle_array_if.sv
// Tick/bus bundle for the time-multiplexed Shadmehr muscle array.
// master drives tick and the per-channel inputs; slave is the engine.
interface shadmehr_muscle_array_if #(
    parameter int NCH = 4
);
    logic              tick;
    logic [32*NCH-1:0] spike_cnt_flat;
    logic [32*NCH-1:0] pos_flat;
    logic [32*NCH-1:0] vel_flat;
    logic [32*NCH-1:0] total_force_flat;
    logic [32*NCH-1:0] active_A_flat;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output tick, spike_cnt_flat, pos_flat, vel_flat,
        input  total_force_flat, active_A_flat, busy, done, overrun
    );

    modport slave (
        input  tick, spike_cnt_flat, pos_flat, vel_flat,
        output total_force_flat, active_A_flat, busy, done, overrun
    );
endinterface

// File: rtl/shadmehr_muscle_array.sv
// Shared-datapath Shadmehr muscle engine, NCH channels, IEEE-754 single.
// Optional macro MUSCLE_FORCE_CLAMP_EN keeps stored force non-negative.
module shadmehr_muscle_array #(
    parameter int          NCH        = 4,
    parameter int unsigned SPIKE_GAIN = 1024,
    parameter logic [31:0] DT_SCALE   = 32'h3A83126F
) (
    input logic                    clk,
    input logic                    reset,
    shadmehr_muscle_array_if.slave bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    localparam logic [31:0] F_HALF  = 32'h3F000000;
    localparam logic [31:0] F_ONE   = 32'h3F800000;
    localparam logic [31:0] F_TWO   = 32'h40000000;
    localparam logic [31:0] F_THREE = 32'h40400000;
    localparam logic [31:0] F_FOUR  = 32'h40800000;
    localparam logic [31:0] F_EIGHT = 32'h41000000;
    localparam logic [31:0] C_A1    = 32'h400BD70A;
    localparam logic [31:0] C_A2    = 32'h400B4396;
    localparam logic [31:0] C_B1    = 32'h3FF892AD;
    localparam logic [31:0] C_B2    = 32'h3F7167AB;
    localparam logic [31:0] C_KP    = 32'h434C0000;
    localparam logic [31:0] C_KV    = 32'h43080000;
    localparam logic [31:0] C_KT    = 32'h40870A3D;
    localparam logic [31:0] C_KA    = 32'h402E147B;

    typedef enum logic [1:0] {IDLE, PH_H, PH_T, PUBLISH} state_t;
    typedef struct packed {
        logic [31:0] s;
        logic [31:0] h;
        logic [31:0] a;
    } stage_t;

    // Round-to-nearest-even pack; denormal results flush to zero.
    function automatic logic [31:0] fpack(logic s, int e, logic [23:0] m,
                                          logic g, logic st);
        logic [24:0] r;
        int          ee;
        ee = e;
        r  = {1'b0, m} + {24'd0, g & (st | m[0])};
        if (r[24]) begin
            r  = r >> 1;
            ee = ee + 1;
        end
        if (ee <= 0) return {s, 31'd0};
        if (ee >= 255) return {s, 8'hFF, 23'd0};
        return {s, ee[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) e = e + 1;
        else p = p << 1;
        return fpack(s, e, p[47:24], p[23], |p[22:0]);
    endfunction

    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
        logic [31:0] x, y;
        logic [27:0] mx, my, sum;
        int          e, d;
        if (a[30:0] < b[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        if (x[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        if (y[30:23] == 8'd0) return x;
        e  = int'(x[30:23]);
        d  = e - int'(y[30:23]);
        mx = {2'b01, x[22:0], 3'b000};
        my = {2'b01, y[22:0], 3'b000};
        if (d > 26) my = 28'd1;
        else if (d > 0)
            my = (my >> d) | {27'd0, |(my & ((28'd1 << d) - 28'd1))};
        sum = (x[31] == y[31]) ? mx + my : mx - my;
        if (sum == 28'd0) return 32'd0;
        if (sum[27]) begin
            sum = (sum >> 1) | {27'd0, sum[0]};
            e   = e + 1;
        end
        for (int i = 0; i < 26; i++)
            if (!sum[26]) begin
                sum = sum << 1;
                e   = e - 1;
            end
        return fpack(x[31], e, sum[26:3], sum[2], |sum[1:0]);
    endfunction

    function automatic logic [31:0] fsub(logic [31:0] a, logic [31:0] b);
        return fadd(a, {~b[31], b[30:0]});
    endfunction

    function automatic logic [31:0] i2f(logic [31:0] v);
        logic [31:0] n;
        int          e;
        if (v == 32'd0) return 32'd0;
        n = v;
        e = 158;
        for (int i = 0; i < 31; i++)
            if (!n[31]) begin
                n = n << 1;
                e = e - 1;
            end
        return fpack(1'b0, e, n[31:8], n[7], |n[6:0]);
    endfunction

    // Raw-bit range tests are only ordered for non-negative lengths.
    function automatic logic [31:0] sweight(logic [31:0] x);
        logic [31:0] x2;
        x2 = fmul(x, x);
        if (x <= F_HALF || x > F_TWO) return 32'd0;
        if (x <= F_ONE)
            return fsub(fsub(fmul(F_EIGHT, x), fmul(F_FOUR, x2)), F_THREE);
        return fsub(fmul(F_TWO, x), x2);
    endfunction

    state_t            state;
    stage_t            stg;
    logic [CW-1:0]     ch;
    logic              busy_q, done_q, ovr_q;
    logic [32*NCH-1:0] spk_q, pos_q, vel_q;
    logic [32*NCH-1:0] s1_q, s2_q, h1_q, h2_q, t_q, dt_q, a_pend;
    logic [32*NCH-1:0] tf_q, af_q;

    logic [31:0] c_spk, c_pos, c_vel, c_s1, c_s2, c_h1, c_h2, c_t, c_dt;
    logic [31:0] s_new, h_new, a_new, dtn, tn, t_wr, dt_wr;

    assign c_spk = spk_q[{ch, 5'd0} +: 32];
    assign c_pos = pos_q[{ch, 5'd0} +: 32];
    assign c_vel = vel_q[{ch, 5'd0} +: 32];
    assign c_s1  = s1_q[{ch, 5'd0} +: 32];
    assign c_s2  = s2_q[{ch, 5'd0} +: 32];
    assign c_h1  = h1_q[{ch, 5'd0} +: 32];
    assign c_h2  = h2_q[{ch, 5'd0} +: 32];
    assign c_t   = t_q[{ch, 5'd0} +: 32];
    assign c_dt  = dt_q[{ch, 5'd0} +: 32];

    assign s_new = i2f(c_spk * SPIKE_GAIN);
    assign h_new = fsub(fadd(fsub(fmul(C_A1, c_s1), fmul(C_A2, c_s2)),
                             fmul(C_B1, c_h1)), fmul(C_B2, c_h2));
    assign a_new = fmul(sweight(c_pos), h_new);
    assign dtn   = fadd(fsub(fadd(fmul(C_KP, fsub(c_pos, F_ONE)),
                                  fmul(C_KV, c_vel)), fmul(C_KT, c_t)),
                        fmul(C_KA, stg.a));
    assign tn    = fadd(c_t, fmul(DT_SCALE, c_dt));

`ifdef MUSCLE_FORCE_CLAMP_EN
    assign t_wr  = tn[31] ? 32'd0 : tn;
    assign dt_wr = (tn[31] && dtn[31]) ? 32'd0 : dtn;
`else
    assign t_wr  = tn;
    assign dt_wr = dtn;
`endif

    assign bus.total_force_flat = tf_q;
    assign bus.active_A_flat    = af_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.overrun          = ovr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            stg    <= '0;
            ch     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            spk_q  <= '0;
            pos_q  <= '0;
            vel_q  <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            h1_q   <= '0;
            h2_q   <= '0;
            t_q    <= '0;
            dt_q   <= '0;
            a_pend <= '0;
            tf_q   <= '0;
            af_q   <= '0;
        end else begin
            done_q <= 1'b0;
            // A tick on the done cycle is treated like one during an update.
            if (bus.tick && (state != IDLE || done_q)) ovr_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.tick && !done_q) begin
                        spk_q  <= bus.spike_cnt_flat;
                        pos_q  <= bus.pos_flat;
                        vel_q  <= bus.vel_flat;
                        ch     <= '0;
                        busy_q <= 1'b1;
                        state  <= PH_H;
                    end
                end
                PH_H: begin
                    stg   <= '{s: s_new, h: h_new, a: a_new};
                    state <= PH_T;
                end
                PH_T: begin
                    s2_q[{ch, 5'd0} +: 32]   <= c_s1;
                    s1_q[{ch, 5'd0} +: 32]   <= stg.s;
                    h2_q[{ch, 5'd0} +: 32]   <= c_h1;
                    h1_q[{ch, 5'd0} +: 32]   <= stg.h;
                    dt_q[{ch, 5'd0} +: 32]   <= dt_wr;
                    t_q[{ch, 5'd0} +: 32]    <= t_wr;
                    a_pend[{ch, 5'd0} +: 32] <= stg.a;
                    if (ch == LAST) begin
                        state <= PUBLISH;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= PH_H;
                    end
                end
                PUBLISH: begin
                    tf_q   <= t_q;
                    af_q   <= a_pend;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shadmehr_muscle_array.sv
// Scoreboard bench for shadmehr_muscle_array with NCH = 4.
// Expectations are queued per update and compared on each done pulse.
module tb_shadmehr_muscle_array;
    localparam int NCH = 4;
    localparam logic [31:0] MZ = 32'h7FFFFFFF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errs = 0;
    int   checks = 0;
    int   n_done = 0;

    shadmehr_muscle_array_if #(.NCH(NCH)) bus ();

    shadmehr_muscle_array #(.NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          ch;
        bit          is_a;
        logic [31:0] mask;
        logic [31:0] val;
        int unsigned tol;
    } exp_t;

    exp_t sb[$];
    int   grp[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] want,
                         int unsigned tol = 0);
        logic [31:0] d;
        checks = checks + 1;
        d = (obs > want) ? obs - want : want - obs;
        if (d > tol) begin
            errs = errs + 1;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic exp_push(string tag, int c, bit is_a, logic [31:0] mask,
                            logic [31:0] v, int unsigned tol);
        exp_t e;
        e.tag  = tag;
        e.ch   = c;
        e.is_a = is_a;
        e.mask = mask;
        e.val  = v;
        e.tol  = tol;
        sb.push_back(e);
    endtask

    // First update from clean state: no history, so every A and T is zero.
    task automatic push_first();
        for (int c = 0; c < NCH; c++) begin
            exp_push($sformatf("u1_T%0d", c), c, 1'b0, MZ, 32'd0, 0);
            exp_push($sformatf("u1_A%0d", c), c, 1'b1, MZ, 32'd0, 0);
        end
        grp.push_back(2 * NCH);
    endtask

    task automatic push_second();
        exp_push("u2_A0", 0, 1'b1, '1, 32'h450BD70A, 0);
        exp_push("u2_T0", 0, 1'b0, MZ, 32'd0, 0);
        exp_push("u2_A1", 1, 1'b1, MZ, 32'd0, 0);
        exp_push("u2_T1", 1, 1'b0, '1, 32'h3DD0E560, 1);
        exp_push("u2_A2", 2, 1'b1, MZ, 32'd0, 0);
`ifdef MUSCLE_FORCE_CLAMP_EN
        exp_push("u2_T2", 2, 1'b0, '1, 32'd0, 0);
`else
        exp_push("u2_T2_sign", 2, 1'b0, 32'h80000000, 32'h80000000, 0);
`endif
        exp_push("u2_A3", 3, 1'b1, MZ, 32'd0, 0);
        exp_push("u2_T3", 3, 1'b0, '1, 32'h3E9CAC08, 1);
        grp.push_back(8);
    endtask

    always @(negedge clk) begin : mon
        int          n;
        exp_t        e;
        logic [31:0] act;
        if (bus.done) begin
            n_done = n_done + 1;
            if (grp.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                n = grp.pop_front();
                for (int i = 0; i < n; i++) begin
                    e   = sb.pop_front();
                    act = e.is_a ? bus.active_A_flat[32*e.ch +: 32]
                                 : bus.total_force_flat[32*e.ch +: 32];
                    check(e.tag, act & e.mask, e.val, e.tol);
                end
            end
        end
    end

    task automatic set_ch(int c, logic [31:0] spk, logic [31:0] pos,
                          logic [31:0] vel);
        bus.spike_cnt_flat[32*c +: 32] = spk;
        bus.pos_flat[32*c +: 32]       = pos;
        bus.vel_flat[32*c +: 32]       = vel;
    endtask

    task automatic run_update(bit extra_tick);
        int lat;
        int nbusy;
        lat   = 0;
        nbusy = 0;
        repeat (2) @(negedge clk);
        bus.tick = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (extra_tick && k == 3) bus.tick = 1'b1;
            @(posedge clk);
            #1 bus.tick = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.done) lat = k;
        end
        check("done_latency", lat, 9);
        check("busy_cycles", nbusy, 8);
    endtask

    initial begin
        int nd;
        bus.tick           = 1'b0;
        bus.spike_cnt_flat = '0;
        bus.pos_flat       = '0;
        bus.vel_flat       = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ovr", bus.overrun, 0);
        check("rst_T0", bus.total_force_flat[31:0], 0);
        check("rst_A0", bus.active_A_flat[31:0], 0);
        reset = 1'b1;

        set_ch(0, 32'd1, 32'h3F800000, 32'd0);
        set_ch(1, 32'd0, 32'h3FC00000, 32'd0);
        set_ch(2, 32'd5, 32'h3ECCCCCD, 32'd0);
        set_ch(3, 32'd7, 32'h40200000, 32'd0);
        push_first();
        run_update(1'b0);
        push_second();
        run_update(1'b0);
        repeat (2) @(negedge clk);
        check("ovr_clear", bus.overrun, 0);

        // Abort an update three edges in; nothing may be published.
        bus.tick = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("abort_T%0d", c),
                  bus.total_force_flat[32*c +: 32], 0);
            check($sformatf("abort_A%0d", c),
                  bus.active_A_flat[32*c +: 32], 0);
        end
        nd = n_done;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        check("abort_no_done", n_done - nd, 0);

        set_ch(2, 32'd0, 32'h3F666666, 32'd0);
        push_first();
        run_update(1'b0);
        push_second();
        run_update(1'b1);
        repeat (2) @(negedge clk);
        check("ovr_set", bus.overrun, 1);
        nd = n_done;
        repeat (30) @(negedge clk);
        check("ovr_no_extra_done", n_done - nd, 0);
        check("ovr_sticky", bus.overrun, 1);
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
